// File: rtl/game_pkg.sv
// Shared types and constants for the artillery turn manager: FSM state
// encoding, health width, default frame counts and the saturating damage helper.
package game_pkg;

  localparam int HP_W              = 8;
  localparam int NUM_PLAYERS_DEF   = 4;
  localparam int TURN_FRAMES_DEF   = 600;
  localparam int SETTLE_FRAMES_DEF = 60;
  localparam int HP_INIT_DEF       = 100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AIM    = 3'd1,
    ST_FLIGHT = 3'd2,
    ST_SETTLE = 3'd3,
    ST_NEXT   = 3'd4,
    ST_OVER   = 3'd5
  } state_e;

  // Health never wraps: overkill damage clamps to zero.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                              input logic [HP_W-1:0] dmg);
    return (hp > dmg) ? (hp - dmg) : '0;
  endfunction

endpackage

// File: rtl/turn_manager_if.sv
// Game-logic bus between the turn manager and the rest of the game:
// shot/explosion/damage events in, turn and health status out.
interface turn_manager_if
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS = NUM_PLAYERS_DEF
) ();

  localparam int PW = $clog2(NUM_PLAYERS);

  logic                        fire;
  logic                        exploded;
  logic                        dmg_valid;
  logic [PW-1:0]               dmg_player;
  logic [HP_W-1:0]             dmg_amount;

  logic [PW-1:0]               active_player;
  logic [NUM_PLAYERS-1:0]      player_enable;
  logic [15:0]                 time_left;
  logic [NUM_PLAYERS*HP_W-1:0] hp;
  logic [NUM_PLAYERS-1:0]      alive;
  logic                        game_over;
  logic [PW-1:0]               winner;
  logic [2:0]                  state;

  modport master (
    output fire, exploded, dmg_valid, dmg_player, dmg_amount,
    input  active_player, player_enable, time_left, hp, alive,
           game_over, winner, state
  );

  modport slave (
    input  fire, exploded, dmg_valid, dmg_player, dmg_amount,
    output active_player, player_enable, time_left, hp, alive,
           game_over, winner, state
  );

endinterface

// File: rtl/frame_tick_sync.sv
// Brings the VGA vsync into the clk domain and emits a one-cycle tick on
// each synchronized rising edge; vsync is only ever sampled as data.
module frame_tick_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_clk_i,
  output logic tick_o
);

  // [0],[1] are the metastability stages, [2] holds the previous level.
  logic [2:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the shift chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk_i};
    end
  end

  assign tick_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/turn_manager.sv
// Turn sequencer for a turn-based artillery game: rotates aiming among living
// players, tracks health from damage strobes and declares a winner.
module turn_manager
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS   = NUM_PLAYERS_DEF,   // legal range 2..8
  parameter int TURN_FRAMES   = TURN_FRAMES_DEF,
  parameter int SETTLE_FRAMES = SETTLE_FRAMES_DEF,
  parameter int HP_INIT       = HP_INIT_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           frame_clk,
  turn_manager_if.slave  bus
);

  localparam int                     PW        = $clog2(NUM_PLAYERS);
  localparam int                     PW1       = PW + 1;
  localparam logic [15:0]            TURN_LD   = 16'(TURN_FRAMES);
  localparam logic [15:0]            SETTLE_LD = 16'(SETTLE_FRAMES);
  localparam logic [HP_W-1:0]        HP_LD     = HP_W'(HP_INIT);
  localparam logic [NUM_PLAYERS-1:0] ONE_HOT0  = NUM_PLAYERS'(1);

  logic tick;

  frame_tick_sync u_frame_tick_sync (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_clk_i (frame_clk),
    .tick_o      (tick)
  );

  state_e                 state_q;
  logic [PW-1:0]          active_q;
  logic [15:0]            time_left_q;
  logic [15:0]            settle_q;
  logic [NUM_PLAYERS-1:0] enable_q;
  logic [NUM_PLAYERS-1:0] alive_q;
  logic                   game_over_q;
  logic [PW-1:0]          winner_q;
  logic                   exploded_q;

  logic [HP_W-1:0]        hp_q [NUM_PLAYERS];
  logic [HP_W-1:0]        hp_d [NUM_PLAYERS];

  logic                   dmg_ok;
  logic [PW-1:0]          next_alive_idx;
  logic [PW-1:0]          lowest_alive_idx;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_PLAYERS) sum = sum - NUM_PLAYERS;
    return PW'(sum);
  endfunction

  // Damage is frozen once the game is decided; out-of-range targets are dropped.
  assign dmg_ok = bus.dmg_valid && (state_q != ST_OVER) &&
                  ({1'b0, bus.dmg_player} < PW1'(NUM_PLAYERS));

  // NOTE: every combinational output gets a default before any conditional
  // write, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hp_d = hp_q;
    if (dmg_ok) begin
      hp_d[bus.dmg_player] = sat_sub(hp_q[bus.dmg_player], bus.dmg_amount);
    end
  end

  // NOTE: the health table is a handful of flops that must start at HP_INIT,
  // so each entry is reset explicitly rather than treated as an uninitialised RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PLAYERS; i++) hp_q[i] <= HP_LD;
      alive_q <= '1;
    end else begin
      hp_q <= hp_d;
      for (int i = 0; i < NUM_PLAYERS; i++) alive_q[i] <= (hp_q[i] != '0);
    end
  end

  // Scan downward so the nearest living successor is the last one written.
  always_comb begin
    next_alive_idx = active_q;
    for (int k = NUM_PLAYERS - 1; k >= 1; k--) begin
      if (alive_q[wrap_add(active_q, k)]) next_alive_idx = wrap_add(active_q, k);
    end
  end

  always_comb begin
    lowest_alive_idx = '0;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      if (alive_q[k]) lowest_alive_idx = PW'(k);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      active_q    <= '0;
      time_left_q <= TURN_LD;
      settle_q    <= '0;
      enable_q    <= '0;
      game_over_q <= 1'b0;
      winner_q    <= '0;
      exploded_q  <= 1'b0;
    end else begin
      exploded_q <= bus.exploded;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q     <= ST_AIM;
            active_q    <= '0;
            time_left_q <= TURN_LD;
            enable_q    <= ONE_HOT0;
          end
        end

        // A dead shooter forfeits; a shot beats a simultaneous timeout.
        ST_AIM: begin
          if (!alive_q[active_q]) begin
            state_q  <= ST_NEXT;
            enable_q <= '0;
          end else if (bus.fire) begin
            state_q  <= ST_FLIGHT;
            enable_q <= '0;
          end else if (tick) begin
            if (time_left_q == '0) begin
              state_q  <= ST_NEXT;
              enable_q <= '0;
            end else begin
              time_left_q <= time_left_q - 16'd1;
            end
          end
        end

        ST_FLIGHT: begin
          if (bus.exploded && !exploded_q) begin
            state_q  <= ST_SETTLE;
            settle_q <= SETTLE_LD;
          end
        end

        ST_SETTLE: begin
          if (!bus.exploded && (settle_q == '0)) begin
            state_q <= ST_NEXT;
          end else if (tick && (settle_q != '0)) begin
            settle_q <= settle_q - 16'd1;
          end
        end

        ST_NEXT: begin
          if ($countones(alive_q) <= 1) begin
            state_q     <= ST_OVER;
            game_over_q <= 1'b1;
            winner_q    <= lowest_alive_idx;
          end else begin
            state_q     <= ST_AIM;
            active_q    <= next_alive_idx;
            time_left_q <= TURN_LD;
            enable_q    <= ONE_HOT0 << next_alive_idx;
          end
        end

        ST_OVER: begin
          state_q <= ST_OVER;
        end

        default: begin
          state_q  <= ST_IDLE;
          enable_q <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_hp_pack
    assign bus.hp[g*HP_W +: HP_W] = hp_q[g];
  end

  assign bus.state         = state_q;
  assign bus.active_player = active_q;
  assign bus.player_enable = enable_q;
  assign bus.time_left     = time_left_q;
  assign bus.alive         = alive_q;
  assign bus.game_over     = game_over_q;
  assign bus.winner        = winner_q;

endmodule
